// File: rtl/i2c_sht40_responder_if.sv
// Open-drain I2C pad bundle seen by the SHT40 responder: SCL/SDA inputs plus the SDA pull-down enable.
interface i2c_sht40_responder_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_sht40_responder.sv
// I2C target emulating an SHT40: takes a one-byte command, then serves the six-byte
// T/H frame with CRC-8 (poly 0x31, init 0xFF). States: IDLE/ADDR/ADDR_ACK/CMD/CMD_ACK/TX/TX_ACK/IGNORE.
module i2c_sht40_responder #(
    parameter logic [6:0] ADDR     = 7'h44,
    parameter logic [7:0] CMD_MEAS = 8'hFD,
    parameter logic [7:0] CMD_SRST = 8'h94
) (
    input  logic        clk,
    input  logic        rst,
    i2c_sht40_responder_if.slave bus,
    input  logic [15:0] temp_word,
    input  logic [15:0] hum_word,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        frame_ready,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_CMD, S_CMD_ACK, S_TX, S_TX_ACK, S_IGNORE
    } state_t;

    function automatic logic [7:0] crc8(input logic [15:0] w);
        logic [7:0] c;
        c = 8'hFF;
        for (int i = 15; i >= 0; i--) begin
            if (c[7] ^ w[i]) c = {c[6:0], 1'b0} ^ 8'h31;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    logic scl_s1, scl_s2, scl_h, sda_s1, sda_s2, sda_h;
    logic scl_rise_q, scl_fall_q, start_q, stop_q, sda_q;

    state_t      state, state_d;
    logic [2:0]  bit_cnt, bit_cnt_d;
    logic [7:0]  shift_q, shift_d, shift_in;
    logic        rw_q, rw_d;
    logic        ack_on, ack_on_d;
    logic [2:0]  byte_idx, idx_d;
    logic        sda_oe_q, oe_d;
    logic        cmd_valid_q, cv_d;
    logic [7:0]  cmd_byte_q, cb_d;
    logic        frame_ready_q, fr_d;
    logic        busy_q, busy_d;
    logic [15:0] temp_q, temp_d, hum_q, hum_d;
    logic [7:0]  crc_t_q, crc_t_d, crc_h_q, crc_h_d;
    logic [7:0]  cur_byte;

    // Edge strobes are registered so a pad edge shows up internally three clocks later.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_h <= 1'b1;
            sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_h <= 1'b1;
            scl_rise_q <= 1'b0; scl_fall_q <= 1'b0;
            start_q <= 1'b0; stop_q <= 1'b0; sda_q <= 1'b1;
        end else begin
            scl_s1 <= bus.scl_in; scl_s2 <= scl_s1; scl_h <= scl_s2;
            sda_s1 <= bus.sda_in; sda_s2 <= sda_s1; sda_h <= sda_s2;
            scl_rise_q <= scl_s2 & ~scl_h;
            scl_fall_q <= ~scl_s2 & scl_h;
            start_q    <= scl_s2 & scl_h & ~sda_s2 & sda_h;
            stop_q     <= scl_s2 & scl_h & sda_s2 & ~sda_h;
            sda_q      <= sda_s2;
        end
    end

    always_comb begin
        cur_byte = temp_q[15:8];
        case (byte_idx)
            3'd1:    cur_byte = temp_q[7:0];
            3'd2:    cur_byte = crc_t_q;
            3'd3:    cur_byte = hum_q[15:8];
            3'd4:    cur_byte = hum_q[7:0];
            3'd5:    cur_byte = crc_h_q;
            default: cur_byte = temp_q[15:8];
        endcase
    end

    always_comb begin
        state_d  = state;
        bit_cnt_d = bit_cnt;
        shift_d  = shift_q;
        rw_d     = rw_q;
        ack_on_d = ack_on;
        idx_d    = byte_idx;
        oe_d     = sda_oe_q;
        cv_d     = 1'b0;
        cb_d     = cmd_byte_q;
        fr_d     = frame_ready_q;
        busy_d   = busy_q;
        temp_d   = temp_q;
        hum_d    = hum_q;
        crc_t_d  = crc_t_q;
        crc_h_d  = crc_h_q;
        shift_in = {shift_q[6:0], sda_q};

        // Bus conditions win over any data edge reported on the same strobe.
        if (stop_q) begin
            state_d  = S_IDLE;
            oe_d     = 1'b0;
            busy_d   = 1'b0;
            ack_on_d = 1'b0;
        end else if (start_q) begin
            state_d   = S_ADDR;
            bit_cnt_d = 3'd0;
            oe_d      = 1'b0;
            ack_on_d  = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_CMD: begin
                    if (scl_rise_q) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (state == S_CMD) begin
                                state_d = S_CMD_ACK;
                            end else if (shift_in[7:1] != ADDR ||
                                         (shift_in[0] && !frame_ready_q)) begin
                                state_d = S_IGNORE;
                                busy_d  = 1'b0;
                            end else begin
                                state_d = S_ADDR_ACK;
                                rw_d    = shift_in[0];
                                busy_d  = 1'b1;
                            end
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall_q) begin
                        if (!ack_on) begin
                            oe_d     = 1'b1;
                            ack_on_d = 1'b1;
                        end else begin
                            ack_on_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            if (rw_q) begin
                                state_d   = S_TX;
                                idx_d     = 3'd0;
                                bit_cnt_d = 3'd7;
                                oe_d      = ~temp_q[15];
                            end else begin
                                state_d = S_CMD;
                                oe_d    = 1'b0;
                            end
                        end
                    end
                end
                S_CMD_ACK: begin
                    if (scl_fall_q) begin
                        if (!ack_on) begin
                            oe_d     = 1'b1;
                            ack_on_d = 1'b1;
                        end else begin
                            ack_on_d  = 1'b0;
                            oe_d      = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = S_CMD;
                            cv_d      = 1'b1;
                            cb_d      = shift_q;
                            if (shift_q == CMD_MEAS) begin
                                temp_d  = temp_word;
                                hum_d   = hum_word;
                                crc_t_d = crc8(temp_word);
                                crc_h_d = crc8(hum_word);
                                fr_d    = 1'b1;
                            end else if (shift_q == CMD_SRST) begin
                                fr_d = 1'b0;
                            end
                        end
                    end
                end
                S_TX: begin
                    if (scl_fall_q) begin
                        if (bit_cnt == 3'd0) begin
                            oe_d     = 1'b0;
                            ack_on_d = 1'b0;
                            state_d  = S_TX_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt - 3'd1;
                            oe_d      = ~cur_byte[bit_cnt - 3'd1];
                        end
                    end
                end
                S_TX_ACK: begin
                    if (scl_rise_q && !ack_on) begin
                        if (byte_idx == 3'd5) fr_d = 1'b0;
                        if (!sda_q) begin
                            ack_on_d = 1'b1;
                            idx_d    = (byte_idx == 3'd5) ? 3'd0 : byte_idx + 3'd1;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end else if (scl_fall_q && ack_on) begin
                        ack_on_d  = 1'b0;
                        state_d   = S_TX;
                        bit_cnt_d = 3'd7;
                        oe_d      = ~cur_byte[7];
                    end
                end
                S_IGNORE: oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            bit_cnt       <= 3'd0;
            shift_q       <= 8'h00;
            rw_q          <= 1'b0;
            ack_on        <= 1'b0;
            byte_idx      <= 3'd0;
            sda_oe_q      <= 1'b0;
            cmd_valid_q   <= 1'b0;
            cmd_byte_q    <= 8'h00;
            frame_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            temp_q        <= 16'h0000;
            hum_q         <= 16'h0000;
            crc_t_q       <= 8'h00;
            crc_h_q       <= 8'h00;
        end else begin
            state         <= state_d;
            bit_cnt       <= bit_cnt_d;
            shift_q       <= shift_d;
            rw_q          <= rw_d;
            ack_on        <= ack_on_d;
            byte_idx      <= idx_d;
            sda_oe_q      <= oe_d;
            cmd_valid_q   <= cv_d;
            cmd_byte_q    <= cb_d;
            frame_ready_q <= fr_d;
            busy_q        <= busy_d;
            temp_q        <= temp_d;
            hum_q         <= hum_d;
            crc_t_q       <= crc_t_d;
            crc_h_q       <= crc_h_d;
        end
    end

    // Reset releases SDA in the same cycle rather than waiting for the clock edge.
    assign bus.sda_oe  = sda_oe_q & ~rst;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_byte    = cmd_byte_q;
    assign frame_ready = frame_ready_q;
    assign busy        = busy_q;

endmodule

// File: doc/i2c_sht40_responder.md
# i2c_sht40_responder

Behavioural-synthesisable I2C target that emulates the SHT40 humidity/temperature sensor: it answers address 0x44, accepts a one-byte measurement command, and returns the six-byte result frame (T_MSB, T_LSB, CRC, H_MSB, H_LSB, CRC) with CRC-8 (poly 0x31, init 0xFF). It is the sensor end of the bus the SHT40 checker and I2C master talk to. It is used as the on-chip stand-in for the sensor in loopback builds and in the master/checker benches.

## Interface
- `ADDR`, default 7'h44, 7-bit target address.
- `CMD_MEAS`, default 8'hFD, measurement command that arms a result frame.
- `CMD_SRST`, default 8'h94, soft-reset command that disarms the frame.
- `clk`  in  1  system clock, at least 16x SCL.
- `rst`  in  1  synchronous, active-high reset.
- `scl_in`  in  1  SCL line, asynchronous.
- `sda_in`  in  1  SDA line, asynchronous.
- `sda_oe`  out  1  1 = pull SDA low (open drain); 0 = release.
- `temp_word`  in  16  temperature value, sampled when a measurement command is accepted.
- `hum_word`  in  16  humidity value, sampled at the same time.
- `cmd_valid`  out  1  one-cycle pulse when a command byte has been ACKed.
- `cmd_byte`  out  8  last received command; valid while `cmd_valid` is high, held afterwards.
- `frame_ready`  out  1  a result frame is armed and not yet fully read.
- `busy`  out  1  high from START to STOP while the transaction is addressed to this target.

## Operation
- **Input conditioning**
  - `scl_in` and `sda_in` each pass through a 2-flop synchroniser, then one history flop, for edge detection.
  - START = SDA falls while SCL is high. STOP = SDA rises while SCL is high.
- **States:** IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, TX, TX_ACK, IGNORE.
- **IDLE:** START -> ADDR with the bit counter cleared.
- **ADDR:** shift 8 bits, MSB first, on SCL rising edges.
  - Address != `ADDR` -> IGNORE.
  - Address match with R/W=0 -> ADDR_ACK, then CMD.
  - Address match with R/W=1 and `frame_ready`=1 -> ADDR_ACK, then TX with byte index 0.
  - Address match with R/W=1 and `frame_ready`=0 -> NACK (leave SDA released), then IGNORE. This mirrors the real sensor's busy NACK.
- **CMD:** shift 8 bits, then CMD_ACK. Every command is ACKed and pulses `cmd_valid`.
  - `CMD_MEAS`: latch `temp_word` and `hum_word`, compute both CRCs, set `frame_ready`.
  - `CMD_SRST`: clear `frame_ready`.
  - Other values: no effect on the frame.
  - After CMD_ACK, extra bytes are ACKed and discarded; the state loops CMD -> CMD_ACK.
- **TX:** drive bit 7..0 of byte[index]. `sda_oe` = ~bit, updated on each SCL falling edge.
  - After the 8th bit, release SDA and sample the master's ACK on the next SCL rising edge.
  - ACK (SDA=0): index+1 and back to TX. After index 5 the index wraps to 0; reads beyond 6 bytes repeat the frame.
  - NACK: -> IGNORE.
  - `frame_ready` clears when byte 5 completes its ACK/NACK slot.
- **IGNORE:** `sda_oe`=0; wait for STOP or START.
- **Global bus events**
  - START in any state (repeated START) -> ADDR.
  - STOP in any state -> IDLE, with `sda_oe` and `busy` cleared.
- **CRC-8**
  - Computed over the 16-bit word, MSB byte first: poly 0x31, init 0xFF, no reflection, no final XOR.
  - Pure function, registered at latch time. Check value: 0xBEEF -> 0x92.

## Timing
- **Reset values:**
  - `sda_oe`, `cmd_valid`, `frame_ready`, `busy` = 0.
  - `cmd_byte` = 8'h00.
  - State = IDLE; latched words and CRCs = 0.
- **Reset mid-transaction:** return to IDLE within the same cycle and release SDA immediately. Bus activity is ignored until the next START.
- **Detection latency:** 3 `clk` cycles from a pad edge to the internal edge strobe. `sda_oe` changes 1 cycle after the strobe, i.e. 4 cycles after the SCL falling pad edge.
- **ACK drive:**
  - `sda_oe` rises on the SCL falling edge after the 8th data bit.
  - It falls on the next SCL falling edge, unless TX starts on that edge; in that case bit 7 is driven instead.
- **`cmd_valid`:** pulses in the cycle the ACK slot ends, on the SCL falling edge.
- **Same-edge conflict:** START/STOP detection has priority over data sampling when both occur on the same strobe.
- **Re-arming:** a new `CMD_MEAS` while `frame_ready`=1 overwrites the frame.
- **Bus speed:** no clock stretching; the block never drives SCL.

## Test plan
- **Write then read:** after reset, write 0x88 (0x44<<1|W), then 0xFD, with `temp_word`=0xBEEF and `hum_word`=0x6666; STOP; then read 0x89 and 6 bytes, NACK on the last. Required:
  - Both write bytes are ACKed and `cmd_valid` pulses with `cmd_byte`=0xFD.
  - Read returns BE EF 92 66 66 93, then `frame_ready`=0.
- **Read with no frame armed:** read 0x89 straight after reset -> address NACKed, `sda_oe` stays 0, `busy`=0 after STOP.
- **Wrong address:** write 0x90 then 0xFD -> both bytes NACKed, no `cmd_valid`, `frame_ready` stays 0.
- **Soft reset:** arm a frame, write 0x94, then read 0x89 -> `cmd_valid` with `cmd_byte`=0x94, and the read address is NACKed.
- **Repeated START and over-read:** arm a frame, START, 0x88, 0xFD, repeated START, 0x89, read 8 bytes with ACK each -> bytes 7-8 are BE EF.
- **Reset mid-TX:** assert `rst` during bit 3 of byte 1 -> `sda_oe`=0 in the same cycle, `frame_ready`=0, and the next transaction behaves as after power-up.
